// File: rtl/usb_pkg.sv
// usb_pkg: shared USB receive types, CRC constants and bit-serial CRC steps.
package usb_pkg;
   typedef enum logic [1:0] {PT_SPECIAL = 2'b00, PT_TOKEN = 2'b01, PT_HANDSHAKE = 2'b10, PT_DATA = 2'b11} pid_type_e;
   typedef enum logic [2:0] {ERR_NONE, ERR_PID, ERR_CRC, ERR_LEN, ERR_OVF, ERR_ABORT} err_e;
   typedef enum logic [2:0] {S_IDLE, S_PID, S_BODY, S_WAIT_EOP, S_DONE} state_e;
   localparam logic [4:0] CRC5_INIT = 5'h1F, CRC5_POLY = 5'h05, CRC5_RES = 5'h0C;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF, CRC16_POLY = 16'h8005, CRC16_RES = 16'h800D;
   function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
      return {c[3:0], 1'b0} ^ ((c[4] ^ b) ? CRC5_POLY : 5'h00);
   endfunction
   function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? CRC16_POLY : 16'h0000);
   endfunction
endpackage

// File: rtl/usb_pkt_rx_buf_if.sv
// usb_pkt_rx_buf_if: payload byte stream with valid/ready flow control.
interface usb_pkt_rx_buf_if;
   logic [7:0] m_data;
   logic m_valid;
   logic m_ready;
   modport master(output m_data, m_valid, input m_ready);
   modport slave(input m_data, m_valid, output m_ready);
endinterface

// File: rtl/usb_byte_fifo.sv
// usb_byte_fifo: first-word-fall-through byte FIFO; head reads 0 while empty.
module usb_byte_fifo #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW:0] wp, rp;
   logic wr, rd;
   assign empty = wp == rp;
   assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign wr = push && (!full || pop);
   assign rd = pop && !empty;
   assign dout = empty ? 8'h00 : mem[rp[AW-1:0]];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr) wp <= wp + 1'b1;
         if (rd) rp <= rp + 1'b1;
      end
   always_ff @(posedge clk)
      if (wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/usb_pkt_rx_buf.sv
// usb_pkt_rx_buf: USB packet receiver with PID/CRC checks, token decode and a
// FIFO-buffered payload stream; every packet ends with a status report.
module usb_pkt_rx_buf
   import usb_pkg::*;
#(
   parameter int MAX_PAYLOAD = 64,
   parameter int FIFO_DEPTH = 8,
   parameter int LEN_W = $clog2(MAX_PAYLOAD + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_start,
   input  logic             rx_status,
   input  logic             rx_bit,
   input  logic             rx_finish,
   output logic [3:0]       pid,
   output logic             pid_valid,
   output logic [6:0]       tok_addr,
   output logic [3:0]       tok_endp,
   output logic [10:0]      sof_frame,
   usb_pkt_rx_buf_if.master m,
   output logic             pkt_done,
   output logic             pkt_ok,
   output logic [2:0]       pkt_err,
   output logic [LEN_W-1:0] pkt_len
);
   state_e state, nxt;
   pid_type_e ptype;
   err_e err;
   logic [2:0] bit_cnt;
   logic [1:0] byte_cnt, held;
   logic [6:0] sh;
   logic [7:0] nb, d0, d1;
   logic [10:0] body;
   logic [4:0] crc5;
   logic [15:0] crc16;
   logic [LEN_W-1:0] len_cnt;
   logic pid_seen, f_pid, f_len, f_ovf;
   logic bit_in, byte_end, pid_ok, at_max, push, pop, full, empty, len_bad, crc_bad;
   assign bit_in = rx_status && !rx_start && (state == S_PID || state == S_BODY || state == S_WAIT_EOP);
   assign nb = {rx_bit, sh};
   assign byte_end = bit_in && bit_cnt == 3'd7;
   assign pid_ok = nb[7:4] == ~nb[3:0];
   assign at_max = len_cnt == LEN_W'(MAX_PAYLOAD);
   // The two newest bytes stay in d0/d1 so the trailing CRC16 is never pushed
   assign push = byte_end && state == S_BODY && ptype == PT_DATA && held == 2'd2 && !at_max;
   assign pop = m.m_valid && m.m_ready;
   assign m.m_valid = !empty;
   assign len_bad = f_len || !pid_seen || bit_cnt != 3'd0 ||
      (ptype == PT_HANDSHAKE ? byte_cnt != 2'd0 : ptype == PT_DATA ? byte_cnt < 2'd2 : byte_cnt != 2'd2);
   assign crc_bad = ptype == PT_HANDSHAKE ? 1'b0 : ptype == PT_DATA ? crc16 != CRC16_RES : crc5 != CRC5_RES;
   assign err = f_pid ? ERR_PID : len_bad ? ERR_LEN : f_ovf ? ERR_OVF : crc_bad ? ERR_CRC : ERR_NONE;
   usb_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(push), .din(d1), .pop(pop),
      .dout(m.m_data), .full(full), .empty(empty)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      if (rx_start) nxt = S_PID;
      else if (state == S_DONE) nxt = S_IDLE;
      else if (rx_finish && state != S_IDLE) nxt = S_DONE;
      else if (state == S_PID && byte_end) nxt = (!pid_ok || nb[1:0] == PT_HANDSHAKE) ? S_WAIT_EOP : S_BODY;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         {pid, pid_valid, tok_addr, tok_endp, sof_frame, pkt_done, pkt_ok, pkt_err, pkt_len} <= '0;
         {bit_cnt, byte_cnt, held, sh, d0, d1, body, len_cnt} <= '0;
         {pid_seen, f_pid, f_len, f_ovf} <= '0;
         ptype <= PT_SPECIAL;
         crc5 <= CRC5_INIT;
         crc16 <= CRC16_INIT;
      end else begin
         pkt_done <= 1'b0;
         if (rx_start) begin
            {bit_cnt, byte_cnt, held, len_cnt, pid_seen, f_pid, f_len, f_ovf, pid_valid} <= '0;
            crc5 <= CRC5_INIT;
            crc16 <= CRC16_INIT;
            pkt_done <= state == S_PID || state == S_BODY;
            pkt_err <= (state == S_PID || state == S_BODY) ? ERR_ABORT : ERR_NONE;
            pkt_ok <= 1'b0;
            pkt_len <= '0;
         end else begin
            if (bit_in) begin
               sh <= nb[7:1];
               bit_cnt <= bit_cnt + 3'd1;
               if (byte_end && state != S_PID && byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
               if (state == S_BODY) begin
                  crc5 <= crc5_step(crc5, rx_bit);
                  crc16 <= crc16_step(crc16, rx_bit);
                  if (byte_cnt == 2'd0 || (byte_cnt == 2'd1 && bit_cnt < 3'd3)) body <= {rx_bit, body[10:1]};
               end
               if (byte_end && state == S_PID) begin
                  pid <= nb[3:0];
                  pid_valid <= pid_ok;
                  pid_seen <= 1'b1;
                  f_pid <= !pid_ok;
                  ptype <= pid_type_e'(nb[1:0]);
               end
               if (byte_end && state == S_BODY && ptype == PT_DATA) begin
                  d0 <= nb;
                  d1 <= d0;
                  if (held != 2'd2) held <= held + 2'd1;
                  else if (at_max) f_len <= 1'b1;
                  else begin
                     len_cnt <= len_cnt + 1'b1;
                     if (full && !pop) f_ovf <= 1'b1;
                  end
               end
            end
            if (state == S_DONE) begin
               pkt_done <= 1'b1;
               pkt_err <= err;
               pkt_ok <= err == ERR_NONE;
               pkt_len <= len_cnt;
               if (ptype == PT_TOKEN && !f_pid && !len_bad) begin
                  tok_addr <= body[6:0];
                  tok_endp <= body[10:7];
                  sof_frame <= body;
               end
            end
         end
      end
endmodule

// File: tb/tb_usb_pkt_rx_buf.sv
// tb_usb_pkt_rx_buf: directed self-checking bench for usb_pkt_rx_buf.
module tb_usb_pkt_rx_buf;
   logic clk = 1'b0, rst_n = 1'b0;
   logic rx_start = 1'b0, rx_status = 1'b0, rx_bit = 1'b0, rx_finish = 1'b0;
   logic [3:0] pid, tok_endp;
   logic pid_valid, pkt_done, pkt_ok;
   logic [6:0] tok_addr, pkt_len;
   logic [10:0] sof_frame;
   logic [2:0] pkt_err;
   logic [15:0] mc16;
   logic [4:0] mc5;
   int checks = 0, passed = 0, fails = 0, n;
   usb_pkt_rx_buf_if bus();
   usb_pkt_rx_buf dut (
      .clk(clk), .rst_n(rst_n), .rx_start(rx_start), .rx_status(rx_status), .rx_bit(rx_bit),
      .rx_finish(rx_finish), .pid(pid), .pid_valid(pid_valid), .tok_addr(tok_addr),
      .tok_endp(tok_endp), .sof_frame(sof_frame), .m(bus), .pkt_done(pkt_done),
      .pkt_ok(pkt_ok), .pkt_err(pkt_err), .pkt_len(pkt_len)
   );
   always #5 clk = ~clk;
   function automatic logic [15:0] c16(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h8005 : 16'h0000);
   endfunction
   function automatic logic [4:0] c5(input logic [4:0] c, input logic b);
      return {c[3:0], 1'b0} ^ ((c[4] ^ b) ? 5'h05 : 5'h00);
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic send_bit(input logic b);
      rx_status = 1'b1;
      rx_bit = b;
      mc16 = c16(mc16, b);
      mc5 = c5(mc5, b);
      tick;
      rx_status = 1'b0;
   endtask
   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
   endtask
   task automatic start;
      rx_start = 1'b1;
      tick;
      rx_start = 1'b0;
   endtask
   task automatic send_pid(input logic [7:0] v);
      send_byte(v);
      mc16 = 16'hFFFF;
      mc5 = 5'h1F;
   endtask
   task automatic send_crc16;
      logic [15:0] c;
      c = ~mc16;
      for (int i = 15; i >= 0; i--) send_bit(c[i]);
   endtask
   task automatic send_crc5;
      logic [4:0] c;
      c = ~mc5;
      for (int i = 4; i >= 0; i--) send_bit(c[i]);
   endtask
   task automatic end_pkt(input string tag);
      rx_finish = 1'b1;
      tick;
      rx_finish = 1'b0;
      tick;
      chk({tag, "_done"}, pkt_done, 1);
   endtask
   initial begin
      bus.m_ready = 1'b0;
      #12 rst_n = 1'b1;
      tick;
      chk("rst_done", pkt_done, 0);
      chk("rst_pid_valid", pid_valid, 0);
      chk("rst_err", pkt_err, 0);
      chk("rst_ok", pkt_ok, 0);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_m_data", bus.m_data, 0);
      // ACK handshake
      start;
      send_pid(8'hD2);
      chk("ack_pid", pid, 4'h2);
      chk("ack_pid_valid", pid_valid, 1);
      end_pkt("ack");
      chk("ack_ok", pkt_ok, 1);
      chk("ack_err", pkt_err, 0);
      chk("ack_len", pkt_len, 0);
      chk("ack_m_valid", bus.m_valid, 0);
      tick;
      chk("ack_done_pulse", pkt_done, 0);
      // SETUP token, good then corrupted CRC
      start;
      send_pid(8'h2D);
      send_byte(8'h00);
      send_byte(8'h10);
      end_pkt("setup");
      chk("setup_ok", pkt_ok, 1);
      chk("setup_addr", tok_addr, 0);
      chk("setup_endp", tok_endp, 0);
      start;
      send_pid(8'h2D);
      send_byte(8'h00);
      send_byte(8'h11);
      end_pkt("setup_bad");
      chk("setup_bad_err", pkt_err, 2);
      chk("setup_bad_ok", pkt_ok, 0);
      chk("setup_bad_endp", tok_endp, 4'h2);
      // zero-length DATA0
      start;
      send_pid(8'hC3);
      send_byte(8'h00);
      send_byte(8'h00);
      end_pkt("zlp");
      chk("zlp_ok", pkt_ok, 1);
      chk("zlp_len", pkt_len, 0);
      chk("zlp_m_valid", bus.m_valid, 0);
      // DATA1 with four payload bytes
      start;
      send_pid(8'h4B);
      send_byte(8'h00);
      send_byte(8'h01);
      chk("d1_held_back", bus.m_valid, 0);
      send_byte(8'h02);
      chk("d1_first_valid", bus.m_valid, 1);
      chk("d1_first_data", bus.m_data, 8'h00);
      send_byte(8'h03);
      send_crc16;
      end_pkt("d1");
      chk("d1_ok", pkt_ok, 1);
      chk("d1_len", pkt_len, 4);
      bus.m_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("d1_drain_valid", bus.m_valid, 1);
         chk("d1_drain_data", bus.m_data, k);
         tick;
      end
      chk("d1_empty", bus.m_valid, 0);
      bus.m_ready = 1'b0;
      // DATA0 with 12 payload bytes into an 8-deep FIFO
      start;
      send_pid(8'hC3);
      for (int k = 0; k < 12; k++) send_byte(8'h10 + 8'(k));
      send_crc16;
      end_pkt("ovf");
      chk("ovf_err", pkt_err, 4);
      chk("ovf_len", pkt_len, 12);
      chk("ovf_ok", pkt_ok, 0);
      bus.m_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.m_valid) begin
            chk("ovf_drain_data", bus.m_data, 8'h10 + n);
            n++;
         end
         tick;
      end
      chk("ovf_drain_count", n, 8);
      bus.m_ready = 1'b0;
      // bad PID
      start;
      send_pid(8'hD3);
      chk("badpid_valid", pid_valid, 0);
      end_pkt("badpid");
      chk("badpid_err", pkt_err, 1);
      // token cut after 20 bits
      start;
      send_pid(8'h69);
      for (int k = 0; k < 12; k++) send_bit(1'b0);
      end_pkt("short");
      chk("short_err", pkt_err, 3);
      // abort at bit 10, then ACK
      start;
      send_pid(8'h69);
      send_bit(1'b1);
      send_bit(1'b0);
      start;
      chk("abort_done", pkt_done, 1);
      chk("abort_err", pkt_err, 5);
      chk("abort_ok", pkt_ok, 0);
      send_pid(8'hD2);
      end_pkt("ack2");
      chk("ack2_ok", pkt_ok, 1);
      chk("ack2_err", pkt_err, 0);
      chk("ack2_pid", pid, 4'h2);
      // asynchronous reset mid data packet
      start;
      send_pid(8'hC3);
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'hCC);
      chk("mid_m_valid", bus.m_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_m_valid", bus.m_valid, 0);
      chk("arst_m_data", bus.m_data, 0);
      chk("arst_pid", pid, 0);
      chk("arst_pid_valid", pid_valid, 0);
      chk("arst_sof", sof_frame, 0);
      chk("arst_err", pkt_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick;
      // SOF with frame 0x7FF
      start;
      send_pid(8'hA5);
      for (int k = 0; k < 11; k++) send_bit(1'b1);
      send_crc5;
      end_pkt("sof");
      chk("sof_ok", pkt_ok, 1);
      chk("sof_frame", sof_frame, 11'h7FF);
      chk("sof_addr", tok_addr, 7'h7F);
      chk("sof_endp", tok_endp, 4'hF);
      chk("sof_m_valid", bus.m_valid, 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/usb_pkt_rx_buf.md
# usb_pkt_rx_buf

Parametrised USB packet receiver with a buffered, flow-controlled payload path. It sits between the bit-level receiver (NRZI decode, unstuffing, SOP/EOP detection) and the protocol engine. It decodes and checks the PID, splits token fields into address/endpoint/frame number, and checks CRC5/CRC16 by residual. Payload bytes, with CRC stripped, go into an internal FIFO drained by a valid/ready handshake, and every packet ends with a status report carrying an error code.

## Interface
- MAX_PAYLOAD, 64: maximum data-packet payload in bytes (1..1023); more bytes sets ERR_LEN.
- FIFO_DEPTH, 8: payload FIFO depth in bytes (power of two, ≥2).
- LEN_W, $clog2(MAX_PAYLOAD+1): width of pkt_len.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_start  in  1  SOP seen; aborts any packet in progress and re-arms.
- rx_status  in  1  rx_bit valid this cycle.
- rx_bit  in  1  received bit, LSB of each byte first.
- rx_finish  in  1  EOP seen; single-cycle pulse.
- pid  out  4  decoded PID (low nibble of first byte).
- pid_valid  out  1  first byte passed the PID/complement check.
- tok_addr  out  7  token device address.
- tok_endp  out  4  token endpoint.
- sof_frame  out  11  SOF frame number.
- m_data  out  8  payload byte at FIFO head.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts m_data when m_valid && m_ready.
- pkt_done  out  1  one-cycle end-of-packet pulse.
- pkt_ok  out  1  packet good; qualified by pkt_done, held until next rx_start.
- pkt_err  out  3  0 none, 1 PID, 2 CRC, 3 LEN (bad bit/byte count), 4 OVF (FIFO full on push), 5 ABORT (rx_start mid-packet).
- pkt_len  out  LEN_W  payload bytes pushed, CRC excluded.

## Operation
- All outputs reset to 0; FSM reset state is IDLE; CRC5 reset 5'h1F, CRC16 reset 16'hFFFF.
- FSM states: IDLE → (rx_start) PID → (8th bit) BODY or, for a handshake, WAIT_EOP → (rx_finish) DONE → (next cycle) IDLE.
- A failed PID check sets err=PID and holds the FSM in WAIT_EOP; later bits are ignored.
- rx_start in any state other than IDLE clears all counters and CRCs and enters PID. It reports pkt_done with err=ABORT if a packet was in progress (PID or BODY state). FIFO contents are kept.
- PID check: bits[7:4] == ~bits[3:0]. PID type is pid[1:0]: 01 token, 11 data, 10 handshake, 00 special. A special PID is received as a token-length packet with no field decode.
- CRC: a bit-serial shift runs over every post-PID bit, including the CRC field. Shift form is x = crc[MSB]^bit, crc = {crc<<1} ^ (x ? POLY : 0), with POLY5 = 5'h05 and POLY16 = 16'h8005. Pass criteria are residual CRC5 == 5'h0C and residual CRC16 == 16'h800D.
- Token (including SOF): exactly 24 bits required. tok_addr = body[6:0], tok_endp = body[10:7], sof_frame = body[10:0], all latched at EOP.
- Data: payload bytes are held back in a 2-byte delay line so the CRC16 bytes are never pushed. On each byte completion the oldest held byte is pushed, pkt_len increments, and pkt_len saturates at MAX_PAYLOAD. A byte beyond MAX_PAYLOAD is dropped and sets LEN.
- Handshake: exactly 8 bits required.
- A bit count at EOP that is not a multiple of 8 sets LEN. A data packet with fewer than 3 bytes sets LEN.
- Error priority: PID > LEN > OVF > CRC.
- A push while the FIFO is full drops the byte and sets OVF. pkt_len still counts the byte.
- pkt_ok = (err==0).

## Timing
- rx_start has priority over rx_status and rx_finish in the same cycle; a bit arriving with rx_start is discarded.
- rx_status and rx_finish in the same cycle: the bit is absorbed first.
- pkt_done is asserted in cycle N+2 for rx_finish in cycle N. pkt_ok, pkt_err, pkt_len and the token fields are stable from N+2 until the next rx_start.
- pid and pid_valid update 1 cycle after the 8th bit.
- A payload byte pushed in cycle N appears on m_valid/m_data in cycle N+1 if the FIFO was empty.
- FIFO push and pop in the same cycle when full succeed; no OVF is raised.
- rx_finish in IDLE is ignored.

## Structure
- Shared package usb_pkg: PID type encodings, err code enum, CRC5/CRC16 init, poly and residual constants, and the CRC step functions.
- One sub-module, usb_byte_fifo: synchronous FIFO with parameter FIFO_DEPTH, push/pop, full/empty, first-word-fall-through output.

## Test plan
- ACK byte 0xD2, then EOP → pid=2, pid_valid=1, pkt_ok=1, pkt_err=0, pkt_len=0, m_valid stays 0.
- SETUP token bytes 0x2D 0x00 0x10 → tok_addr=0, tok_endp=0, pkt_ok=1. The same with the last byte 0x11 → pkt_err=2 (CRC).
- DATA0 bytes 0xC3 0x00 0x00 (zero-length) → pkt_ok=1, pkt_len=0. DATA1 carrying 4 bytes 0x00..0x03 plus a model-computed CRC16 → four bytes out in order, pkt_len=4, pkt_ok=1.
- FIFO_DEPTH=8, DATA0 with 12 payload bytes and m_ready=0 → 8 bytes held, pkt_err=4, pkt_len=12. Release m_ready → exactly 8 bytes drain.
- PID byte 0xD3 → pid_valid=0, pkt_err=1. Token cut after 20 bits → pkt_err=3. rx_start at bit 10 of a token → pkt_done with pkt_err=5, then the following ACK decodes normally.
- rst_n asserted mid data packet → all outputs 0 asynchronously and FIFO empty. A following SOF with frame 0x7FF reports sof_frame=0x7FF.
